// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: count width and parameter legality.
package fifo_pkg;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Rejects non-power-of-two depths and thresholds outside their legal ranges.
  function automatic bit params_ok(input int data_w, input int depth,
                                   input int af_thresh, input int ae_thresh);
    bit ok;
    ok = 1'b1;
    if (data_w < 1) ok = 1'b0;
    if (depth < 2) ok = 1'b0;
    if ((depth & (depth - 1)) != 0) ok = 1'b0;
    if (af_thresh < 1 || af_thresh > depth) ok = 1'b0;
    if (ae_thresh < 0 || ae_thresh > depth - 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one
// asynchronous read port, intended to map onto distributed RAM.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array so it stays a plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags,
// synchronous flush and optional first-word-fall-through read.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [DATA_W-1:0]             din,
  input  logic                          wr_en,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             dout,
  output logic                          empty,
  output logic                          almost_empty,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  generate
    if (!params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
      $error("sync_fifo: illegal DATA_W/DEPTH/AF_THRESH/AE_THRESH combination");
    end
  endgenerate

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_ok;
  logic              rd_ok;

  // Flags decode only from the registered count, never from wr_en/rd_en.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // A pop frees a slot in the same cycle, so a full FIFO can accept a write.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok & ~flush),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
      if (wr_en & full & ~rd_ok) overflow <= 1'b1;
      if (rd_en & empty) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; zero is shown while empty.
      assign dout = empty ? '0 : mem_rdata;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
        end else if (flush) begin
          dout_q <= '0;
        end else if (rd_ok) begin
          dout_q <= mem_rdata;
        end
      end

      assign dout = dout_q;
    end
  endgenerate

endmodule
